conv_layer_controller: RTL and testbench



---
 rtl/conv_layer_pkg.sv | 39 +++
 rtl/conv_ctrl_counter.sv | 66 ++++++
 rtl/conv_layer_controller.sv | 210 +++++++++++++++++++++
 tb/tb_conv_layer_controller.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_pkg.sv
// ---------------------------------------------------------------------------
// conv_layer_pkg
// Shared definitions between the convolution layer controller and the
// convolution input interface: command/ack encodings, the controller state
// enumeration and small helper functions.
// ---------------------------------------------------------------------------
package conv_layer_pkg;

  typedef logic [1:0] cmd_t;
  typedef logic [1:0] ack_t;

  localparam cmd_t CMD_IDLE    = 2'd0;
  localparam cmd_t CMD_PRELOAD = 2'd1;
  localparam cmd_t CMD_SHIFT   = 2'd2;
  localparam cmd_t CMD_LOAD    = 2'd3;

  localparam ack_t ACK_IDLE        = 2'd0;
  localparam ack_t ACK_PRELOAD_FIN = 2'd1;
  localparam ack_t ACK_SHIFT_FIN   = 2'd2;
  localparam ack_t ACK_LOAD_FIN    = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PRE_ISS  = 4'd1,
    S_PRE_WAIT = 4'd2,
    S_SH_ISS   = 4'd3,
    S_SH_WAIT  = 4'd4,
    S_LD_ISS   = 4'd5,
    S_LD_WAIT  = 4'd6,
    S_DONE     = 4'd7,
    S_ERR      = 4'd8
  } ctrl_state_t;

  // True in the states where the controller is waiting for an interface ack.
  function automatic logic is_wait_state(input ctrl_state_t s);
    return (s == S_PRE_WAIT) || (s == S_SH_WAIT) || (s == S_LD_WAIT);
  endfunction

endpackage

// File: rtl/conv_ctrl_counter.sv
// ---------------------------------------------------------------------------
// conv_ctrl_counter
// Row / column (shift) position counters for the convolution controller.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clr                   clear both counters (end of pass)
//   col_inc               advance column by one
//   col_wrap              return column to zero (end of row)
//   row_inc               advance row by one
//   row_idx, col_idx      current position
//   col_last, row_last    position is the last shift / last output row
// ---------------------------------------------------------------------------
module conv_ctrl_counter #(
  parameter int SHIFTS_PER_ROW = 30,
  parameter int OUT_ROWS       = 30,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 col_inc,
  input  logic                 col_wrap,
  input  logic                 row_inc,
  output logic [CNT_WIDTH-1:0] row_idx,
  output logic [CNT_WIDTH-1:0] col_idx,
  output logic                 col_last,
  output logic                 row_last
);

  localparam logic [CNT_WIDTH-1:0] COL_MAX = CNT_WIDTH'(SHIFTS_PER_ROW - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_MAX = CNT_WIDTH'(OUT_ROWS - 1);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] row_r;
  logic [CNT_WIDTH-1:0] col_r;

  // Position counters; clr has priority so the pass always ends at (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r <= '0;
      col_r <= '0;
    end else if (clr) begin
      row_r <= '0;
      col_r <= '0;
    end else begin
      if (col_wrap) begin
        col_r <= '0;
      end else if (col_inc) begin
        col_r <= col_r + ONE;
      end else begin
        col_r <= col_r;
      end
      if (row_inc) begin
        row_r <= row_r + ONE;
      end else begin
        row_r <= row_r;
      end
    end
  end

  assign row_idx  = row_r;
  assign col_idx  = col_r;
  assign col_last = (col_r == COL_MAX);
  assign row_last = (row_r == ROW_MAX);

endmodule

// File: rtl/conv_layer_controller.sv
// ---------------------------------------------------------------------------
// conv_layer_controller
// Sequences one feature-map pass on the convolution input interface:
// PRELOAD, then per output row a run of SHIFTs followed by a LOAD (no LOAD
// after the last row). Each command is a one-cycle pulse, then the controller
// waits for the matching ack. hold stalls command issue, never ack sampling.
// Optional feature macro: CONV_CTRL_TIMEOUT_EN (ack watchdog, adds err port
// and the TIMEOUT_CYCLES parameter).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse to begin a pass (ignored while busy)
//   hold            downstream stall
//   ack             registered interface acknowledge
//   cmd             interface command pulse
//   intf_enable     interface advance enable
//   busy            pass in progress
//   window_valid    pulse per accepted SHIFT_FIN
//   row_idx/col_idx current output row / shift within row
//   done            pulse at end of pass
//   err             (timeout build) watchdog fired, sticky until reset
// ---------------------------------------------------------------------------
module conv_layer_controller
  import conv_layer_pkg::*;
#(
  parameter int IMAGE_SIZE     = 32,
  parameter int KERNEL_SIZE    = 3,
  parameter int SHIFTS_PER_ROW = IMAGE_SIZE - KERNEL_SIZE + 1,
  parameter int OUT_ROWS       = IMAGE_SIZE - KERNEL_SIZE + 1,
  parameter int CNT_WIDTH      = 6
`ifdef CONV_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 hold,
  input  logic [1:0]           ack,
  output logic [1:0]           cmd,
  output logic                 intf_enable,
  output logic                 busy,
  output logic                 window_valid,
  output logic [CNT_WIDTH-1:0] row_idx,
  output logic [CNT_WIDTH-1:0] col_idx,
  output logic                 done
`ifdef CONV_CTRL_TIMEOUT_EN
  , output logic               err
`endif
);

  ctrl_state_t state_r, next_s;
  cmd_t        cmd_r, cmd_s;
  logic        busy_r, intf_en_r, wv_r, done_r, wv_s;
  logic        cnt_clr_s, col_inc_s, col_wrap_s, row_inc_s;
  logic        col_last_s, row_last_s, timeout_s;

  conv_ctrl_counter #(
    .SHIFTS_PER_ROW (SHIFTS_PER_ROW),
    .OUT_ROWS       (OUT_ROWS),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr_s),
    .col_inc  (col_inc_s),
    .col_wrap (col_wrap_s),
    .row_inc  (row_inc_s),
    .row_idx  (row_idx),
    .col_idx  (col_idx),
    .col_last (col_last_s),
    .row_last (row_last_s)
  );

`ifdef CONV_CTRL_TIMEOUT_EN
  localparam int                WAIT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES - 1);
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              err_r;

  // Wait-cycle counter: zero outside WAIT states, so it starts at 0 on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= '0;
    end else if (is_wait_state(state_r)) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (next_s == S_ERR);
    end
  end

  assign timeout_s = (wait_cnt_r == WAIT_MAX);
  assign err       = err_r;
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and per-cycle command/counter decisions.
  always_comb begin
    next_s     = state_r;
    cmd_s      = CMD_IDLE;
    wv_s       = 1'b0;
    cnt_clr_s  = 1'b0;
    col_inc_s  = 1'b0;
    col_wrap_s = 1'b0;
    row_inc_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) next_s = S_PRE_ISS;
        else       next_s = S_IDLE;
      end
      S_PRE_ISS: begin
        if (!hold) begin
          cmd_s  = CMD_PRELOAD;
          next_s = S_PRE_WAIT;
        end else begin
          next_s = S_PRE_ISS;
        end
      end
      S_PRE_WAIT: begin
        if (ack == ACK_PRELOAD_FIN) next_s = S_SH_ISS;
        else if (timeout_s)         next_s = S_ERR;
        else                        next_s = S_PRE_WAIT;
      end
      S_SH_ISS: begin
        if (!hold) begin
          cmd_s  = CMD_SHIFT;
          next_s = S_SH_WAIT;
        end else begin
          next_s = S_SH_ISS;
        end
      end
      S_SH_WAIT: begin
        if (ack == ACK_SHIFT_FIN) begin
          wv_s = 1'b1;
          if (!col_last_s) begin
            col_inc_s = 1'b1;
            next_s    = S_SH_ISS;
          end else if (!row_last_s) begin
            col_wrap_s = 1'b1;
            next_s     = S_LD_ISS;
          end else begin
            // Last window of the pass: both counters return to zero.
            cnt_clr_s = 1'b1;
            next_s    = S_DONE;
          end
        end else if (timeout_s) begin
          next_s = S_ERR;
        end else begin
          next_s = S_SH_WAIT;
        end
      end
      S_LD_ISS: begin
        if (!hold) begin
          cmd_s  = CMD_LOAD;
          next_s = S_LD_WAIT;
        end else begin
          next_s = S_LD_ISS;
        end
      end
      S_LD_WAIT: begin
        if (ack == ACK_LOAD_FIN) begin
          row_inc_s = 1'b1;
          next_s    = S_SH_ISS;
        end else if (timeout_s) begin
          next_s = S_ERR;
        end else begin
          next_s = S_LD_WAIT;
        end
      end
      S_DONE:  next_s = S_IDLE;
      S_ERR:   next_s = S_ERR;
      default: next_s = S_IDLE;
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cmd_r     <= CMD_IDLE;
      busy_r    <= 1'b0;
      intf_en_r <= 1'b0;
      wv_r      <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= next_s;
      cmd_r     <= cmd_s;
      busy_r    <= (next_s != S_IDLE);
      intf_en_r <= (next_s != S_IDLE) && (next_s != S_ERR);
      wv_r      <= wv_s;
      done_r    <= (next_s == S_DONE);
    end
  end

  assign cmd          = cmd_r;
  assign busy         = busy_r;
  assign intf_enable  = intf_en_r;
  assign window_valid = wv_r;
  assign done         = done_r;

endmodule

// File: tb/tb_conv_layer_controller.sv
// ---------------------------------------------------------------------------
// tb_conv_layer_controller
// Self-checking bench: a responsive interface model answers each command
// after a (fixed or random) delay; a behavioural model predicts the command
// sequence, window positions, busy/done and indices every cycle.
// ---------------------------------------------------------------------------
module tb_conv_layer_controller;
  import conv_layer_pkg::*;

  localparam int IMG   = 6;
  localparam int KS    = 3;
  localparam int SPR   = IMG - KS + 1;
  localparam int ORW   = IMG - KS + 1;
  localparam int TOTAL = SPR * ORW;
  localparam int CW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [1:0]    ack = 2'd0;
  logic [1:0]    cmd;
  logic          intf_enable, busy, window_valid, done;
  logic [CW-1:0] row_idx, col_idx;
`ifdef CONV_CTRL_TIMEOUT_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  conv_layer_controller #(
    .IMAGE_SIZE  (IMG),
    .KERNEL_SIZE (KS),
    .CNT_WIDTH   (CW)
`ifdef CONV_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .hold         (hold),
    .ack          (ack),
    .cmd          (cmd),
    .intf_enable  (intf_enable),
    .busy         (busy),
    .window_valid (window_valid),
    .row_idx      (row_idx),
    .col_idx      (col_idx),
    .done         (done)
`ifdef CONV_CTRL_TIMEOUT_EN
    , .err        (err)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- interface model and stimulus drivers ----------------
  logic [1:0] inj_ack = 2'd0;
  bit         ack_mute = 1'b0, rand_delay = 1'b0, hold_rand = 1'b0, hold_dir = 1'b0;
  bit         cmp_en = 1'b1;
  int         pend = 0;
  logic [1:0] pend_ack = 2'd0;

  always @(negedge clk) begin
    logic [1:0] a;
    if (!rst_n) begin
      pend = 0;
      ack  = ACK_IDLE;
    end else begin
      a = ACK_IDLE;
      if (inj_ack != ACK_IDLE) begin
        a       = inj_ack;
        inj_ack = ACK_IDLE;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !ack_mute) a = pend_ack;
      end
      if (cmd != CMD_IDLE) begin
        pend     = rand_delay ? int'($urandom_range(1, 6)) : 5;
        pend_ack = cmd;  // each FIN ack shares its command's code
      end
      ack = a;
    end
  end

  always @(negedge clk) hold = hold_rand ? ($urandom_range(0, 3) == 0) : hold_dir;

  // ---------------- behavioural model + per-cycle compare ----------------
  bit   m_busy = 1'b0, last_done = 1'b0;
  cmd_t outstanding = CMD_IDLE;
  cmd_t exp_q[$];
  int   win_cnt = 0, m_row = 0, m_col = 0;
  int   n_pre = 0, n_sh = 0, n_ld = 0, n_done = 0, n_win = 0, max_row = 0;

  always begin
    cmd_t old_out;
    bit   matched, wv_exp, done_exp;
    int   k;
    @(posedge clk); #1;
    if (!rst_n || !cmp_en) begin
      m_busy = 1'b0; last_done = 1'b0; outstanding = CMD_IDLE;
      exp_q.delete(); win_cnt = 0; m_row = 0; m_col = 0;
    end else begin
      old_out  = outstanding;
      matched  = (old_out != CMD_IDLE) && (ack == old_out);
      wv_exp   = matched && (old_out == CMD_SHIFT);
      done_exp = 1'b0;
      if (last_done) begin
        m_busy = 1'b0;
      end else if (!m_busy && start) begin
        m_busy  = 1'b1;
        win_cnt = 0;
        exp_q.push_back(CMD_PRELOAD);
        for (int r = 0; r < ORW; r++) begin
          for (int c = 0; c < SPR; c++) exp_q.push_back(CMD_SHIFT);
          if (r < ORW - 1) exp_q.push_back(CMD_LOAD);
        end
      end
      if (cmd != CMD_IDLE) begin
        chk("cmd_before_ack", int'(old_out), int'(CMD_IDLE));
        chk("cmd_under_hold", int'(hold), 0);
        if (exp_q.size() == 0) chk("cmd_unexpected", int'(cmd), int'(CMD_IDLE));
        else                   chk("cmd_order", int'(cmd), int'(exp_q.pop_front()));
        if (cmd == CMD_PRELOAD) n_pre++;
        if (cmd == CMD_SHIFT)   n_sh++;
        if (cmd == CMD_LOAD)    n_ld++;
        outstanding = cmd;
      end else if (matched) begin
        outstanding = CMD_IDLE;
      end
      if (wv_exp) begin
        k = win_cnt;
        win_cnt++;
        if (k % SPR < SPR - 1) begin
          m_row = k / SPR; m_col = k % SPR + 1;
        end else if (k / SPR < ORW - 1) begin
          m_row = k / SPR; m_col = 0;
        end else begin
          m_row = 0; m_col = 0; done_exp = 1'b1;
          chk("queue_empty_at_done", exp_q.size(), 0);
        end
      end
      if (matched && old_out == CMD_LOAD) m_row++;
      chk("busy", int'(busy), int'(m_busy));
      chk("intf_enable", int'(intf_enable), int'(m_busy));
      chk("window_valid", int'(window_valid), int'(wv_exp));
      chk("done", int'(done), int'(done_exp));
      chk("row_idx", int'(row_idx), m_row);
      chk("col_idx", int'(col_idx), m_col);
      if (window_valid) n_win++;
      if (done) n_done++;
      if (int'(row_idx) > max_row) max_row = int'(row_idx);
      last_done = done_exp;
    end
  end

  // ---------------- helper tasks ----------------
  task automatic clr_counts();
    n_pre = 0; n_sh = 0; n_ld = 0; n_done = 0; n_win = 0; max_row = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, int'(seen), 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_windows(input int n);
    int w = 0;
    for (int i = 0; i < 3000 && w < n; i++) begin
      @(posedge clk); #1;
      if (window_valid) w++;
    end
    chk("window_wait", w, n);
  endtask

  task automatic check_pass_counts(input string nm);
    chk({nm, "_preloads"}, n_pre, 1);
    chk({nm, "_shifts"}, n_sh, TOTAL);
    chk({nm, "_loads"}, n_ld, ORW - 1);
    chk({nm, "_windows"}, n_win, TOTAL);
    chk({nm, "_dones"}, n_done, 1);
    chk({nm, "_max_row"}, max_row, ORW - 1);
    chk({nm, "_busy_after"}, int'(busy), 0);
  endtask

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit seen;
    int idle_cnt;
    #7;
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_intf_enable", int'(intf_enable), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_row_col", int'(row_idx) + int'(col_idx), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: full pass with fixed-delay interface; exact start latency.
    clr_counts();
    pulse_start();
    @(posedge clk); #1;
    chk("start_to_preload", int'(cmd), int'(CMD_PRELOAD));
    wait_done("pass1");
    check_pass_counts("pass1");

    // 2: hold for 10 cycles in S_SH_ISS after the 5th window.
    clr_counts();
    pulse_start();
    wait_windows(5);
    hold_dir = 1'b1;
    idle_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (cmd == CMD_IDLE) idle_cnt++;
    end
    hold_dir = 1'b0;
    chk("hold_idle_cycles", idle_cnt, 10);
    @(posedge clk); #1;
    chk("hold_release_shift", int'(cmd), int'(CMD_SHIFT));
    chk("hold_row", int'(row_idx), 1);
    chk("hold_col", int'(col_idx), 1);
    wait_done("pass2");
    check_pass_counts("pass2");

    // 3: stray LOAD_FIN while waiting for the first SHIFT_FIN.
    clr_counts();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (cmd == CMD_SHIFT) seen = 1'b1;
    end
    chk("first_shift_seen", int'(seen), 1);
    inj_ack = ACK_LOAD_FIN;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_ack_row", int'(row_idx), 0);
    chk("stray_ack_col", int'(col_idx), 0);
    chk("stray_ack_windows", n_win, 0);
    wait_done("pass3");
    check_pass_counts("pass3");

    // 4: random delays and hold, extra start mid-pass.
    clr_counts();
    rand_delay = 1'b1;
    hold_rand  = 1'b1;
    pulse_start();
    wait_windows(7);
    pulse_start();
    wait_done("pass4");
    hold_rand = 1'b0;
    @(negedge clk);
    check_pass_counts("pass4");
    rand_delay = 1'b0;

    // 5: asynchronous reset at row 2, then a fresh full pass.
    clr_counts();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      if (row_idx == CW'(2)) seen = 1'b1;
    end
    chk("reached_row2", int'(seen), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd", int'(cmd), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_intf_enable", int'(intf_enable), 0);
    chk("arst_window_valid", int'(window_valid), 0);
    chk("arst_row", int'(row_idx), 0);
    chk("arst_col", int'(col_idx), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clr_counts();
    pulse_start();
    @(posedge clk); #1;
    chk("post_reset_preload", int'(cmd), int'(CMD_PRELOAD));
    wait_done("pass5");
    check_pass_counts("pass5");

`ifdef CONV_CTRL_TIMEOUT_EN
    // 6: withheld SHIFT_FIN triggers the watchdog.
    chk("err_reset_value", int'(err), 0);
    cmp_en = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (cmd == CMD_SHIFT) seen = 1'b1;
    end
    ack_mute = 1'b1;
    idle_cnt = 0;
    for (int i = 1; i <= 40 && idle_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (err) idle_cnt = i;
    end
    chk("err_latency", idle_cnt, 16);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", int'(err), 1);
    chk("err_cmd", int'(cmd), 0);
    chk("err_intf_enable", int'(intf_enable), 0);
    chk("err_busy", int'(busy), 1);
    @(negedge clk) rst_n = 1'b0;
    #1 chk("err_cleared", int'(err), 0);
    ack_mute = 1'b0;
    @(negedge clk) rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
